// File: rtl/pipe_stage_elastic_pkg.sv
// Shared constants and helpers for the elastic pipeline stage: bubble values,
// register-zero index and the saturating Tnew decrement.
package pipe_stage_elastic_pkg;

    localparam int          TNEW_MAX_DEFAULT = 7;
    localparam logic [31:0] NOP_WORD         = 32'h0;
    localparam logic [31:0] BUBBLE_PC        = 32'h0;
    localparam logic [4:0]  REG_ZERO         = 5'd0;
    localparam int          MAIN             = 0;
    localparam int          SKID             = 1;
    localparam int          N_ENTRY          = 2;

    // Tnew counts down towards 0 and sticks there.
    function automatic int unsigned sat_dec(input int unsigned value);
        return (value > 32'd0) ? value - 32'd1 : 32'd0;
    endfunction

endpackage

// File: rtl/pipe_stage_elastic_pipe_entry.sv
// One stage entry: valid bit plus instr/pc/payload/wreg/tnew, with
// clear (to bubble), load and tnew aging controls. clear wins over load.
module pipe_entry
    import pipe_stage_elastic_pkg::*;
#(
    parameter int DATA_W   = 128,
    parameter int TNEW_W   = 3,
    parameter int TNEW_MAX = TNEW_MAX_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              load,
    input  logic              age,
    input  logic              d_valid,
    input  logic [31:0]       d_instr,
    input  logic [31:0]       d_pc,
    input  logic [DATA_W-1:0] d_data,
    input  logic [4:0]        d_wreg,
    input  logic [TNEW_W-1:0] d_tnew,
    output logic              q_valid,
    output logic [31:0]       q_instr,
    output logic [31:0]       q_pc,
    output logic [DATA_W-1:0] q_data,
    output logic [4:0]        q_wreg,
    output logic [TNEW_W-1:0] q_tnew
);

    logic              valid_reg;
    logic [31:0]       instr_reg;
    logic [31:0]       pc_reg;
    logic [DATA_W-1:0] data_reg;
    logic [4:0]        wreg_reg;
    logic [TNEW_W-1:0] tnew_reg;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            valid_reg <= 1'b0;
            instr_reg <= NOP_WORD;
            pc_reg    <= BUBBLE_PC;
            data_reg  <= '0;
            wreg_reg  <= REG_ZERO;
            tnew_reg  <= TNEW_W'(TNEW_MAX);
        end else if (load) begin
            valid_reg <= d_valid;
            instr_reg <= d_instr;
            pc_reg    <= d_pc;
            data_reg  <= d_data;
            wreg_reg  <= d_wreg;
            tnew_reg  <= d_tnew;
        end else if (age && valid_reg) begin
            tnew_reg  <= TNEW_W'(sat_dec(32'(tnew_reg)));
        end
    end

    assign q_valid = valid_reg;
    assign q_instr = instr_reg;
    assign q_pc    = pc_reg;
    assign q_data  = data_reg;
    assign q_wreg  = wreg_reg;
    assign q_tnew  = tnew_reg;

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic MIPS inter-stage register: MAIN + SKID entries, valid/ready handshake,
// flush, saturating Tnew and forwarding tap. Define PIPE_TNEW_AGE_EN to age held entries.
module pipe_stage_elastic
    import pipe_stage_elastic_pkg::*;
#(
    parameter int DATA_W   = 128,
    parameter int TNEW_W   = 3,
    parameter int TNEW_MAX = TNEW_MAX_DEFAULT,
    parameter int FWD_LSB  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic [31:0]       in_pc,
    input  logic [DATA_W-1:0] in_data,
    input  logic [4:0]        in_wreg,
    input  logic [TNEW_W-1:0] in_tnew,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [31:0]       out_pc,
    output logic [DATA_W-1:0] out_data,
    output logic [4:0]        out_wreg,
    output logic [TNEW_W-1:0] out_tnew,
    output logic              fwd_en,
    output logic [31:0]       fwd_val
);

`ifdef PIPE_TNEW_AGE_EN
    localparam bit AGE_EN = 1'b1;
`else
    localparam bit AGE_EN = 1'b0;
`endif

    logic [N_ENTRY-1:0] load_vec;
    logic [N_ENTRY-1:0] clear_vec;
    logic [N_ENTRY-1:0] age_vec;
    logic               main_from_skid;
    logic               accept_fire;
    logic               rel_fire;
    logic [TNEW_W-1:0]  cap_tnew;

    logic              d_valid [N_ENTRY];
    logic [31:0]       d_instr [N_ENTRY];
    logic [31:0]       d_pc    [N_ENTRY];
    logic [DATA_W-1:0] d_data  [N_ENTRY];
    logic [4:0]        d_wreg  [N_ENTRY];
    logic [TNEW_W-1:0] d_tnew  [N_ENTRY];
    logic              q_valid [N_ENTRY];
    logic [31:0]       q_instr [N_ENTRY];
    logic [31:0]       q_pc    [N_ENTRY];
    logic [DATA_W-1:0] q_data  [N_ENTRY];
    logic [4:0]        q_wreg  [N_ENTRY];
    logic [TNEW_W-1:0] q_tnew  [N_ENTRY];

    // in_ready depends only on registered SKID state, so back-pressure never
    // forms a combinational path from out_ready.
    assign in_ready    = !q_valid[SKID];
    assign accept_fire = in_valid && in_ready;
    assign rel_fire    = q_valid[MAIN] && out_ready;
    assign cap_tnew    = TNEW_W'(sat_dec(32'(in_tnew)));

    always_comb begin
        load_vec       = '0;
        clear_vec      = '0;
        main_from_skid = 1'b0;
        if (flush) begin
            clear_vec = '1;
        end else if (!q_valid[MAIN]) begin
            load_vec[MAIN] = accept_fire;
        end else if (rel_fire) begin
            if (q_valid[SKID]) begin
                load_vec[MAIN]  = 1'b1;
                main_from_skid  = 1'b1;
                clear_vec[SKID] = 1'b1;
            end else if (accept_fire) begin
                load_vec[MAIN]  = 1'b1;
            end else begin
                clear_vec[MAIN] = 1'b1;
            end
        end else begin
            load_vec[SKID] = accept_fire;
        end
    end

    // Held entries age; a MAIN<-SKID move carries tnew unchanged.
    assign age_vec = {N_ENTRY{AGE_EN && !rel_fire}};

    always_comb begin
        d_valid[SKID] = 1'b1;
        d_instr[SKID] = in_instr;
        d_pc[SKID]    = in_pc;
        d_data[SKID]  = in_data;
        d_wreg[SKID]  = in_wreg;
        d_tnew[SKID]  = cap_tnew;
        d_valid[MAIN] = 1'b1;
        d_instr[MAIN] = main_from_skid ? q_instr[SKID] : in_instr;
        d_pc[MAIN]    = main_from_skid ? q_pc[SKID]    : in_pc;
        d_data[MAIN]  = main_from_skid ? q_data[SKID]  : in_data;
        d_wreg[MAIN]  = main_from_skid ? q_wreg[SKID]  : in_wreg;
        d_tnew[MAIN]  = main_from_skid ? q_tnew[SKID]  : cap_tnew;
    end

    generate
        for (genvar gi = 0; gi < N_ENTRY; gi++) begin : g_entry
            pipe_entry #(
                .DATA_W   (DATA_W),
                .TNEW_W   (TNEW_W),
                .TNEW_MAX (TNEW_MAX)
            ) u_entry (
                .clk     (clk),
                .reset   (reset),
                .clear   (clear_vec[gi]),
                .load    (load_vec[gi]),
                .age     (age_vec[gi]),
                .d_valid (d_valid[gi]),
                .d_instr (d_instr[gi]),
                .d_pc    (d_pc[gi]),
                .d_data  (d_data[gi]),
                .d_wreg  (d_wreg[gi]),
                .d_tnew  (d_tnew[gi]),
                .q_valid (q_valid[gi]),
                .q_instr (q_instr[gi]),
                .q_pc    (q_pc[gi]),
                .q_data  (q_data[gi]),
                .q_wreg  (q_wreg[gi]),
                .q_tnew  (q_tnew[gi])
            );
        end
    endgenerate

    assign out_valid = q_valid[MAIN];
    assign out_instr = q_instr[MAIN];
    assign out_pc    = q_pc[MAIN];
    assign out_data  = q_data[MAIN];
    assign out_wreg  = q_wreg[MAIN];
    assign out_tnew  = q_tnew[MAIN];
    assign fwd_en    = q_valid[MAIN] && (q_wreg[MAIN] != REG_ZERO) && (q_tnew[MAIN] == '0);
    assign fwd_val   = q_data[MAIN][FWD_LSB +: 32];

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Scoreboard bench for pipe_stage_elastic: the model is an in-order FIFO of
// accepted instructions (capacity 2) with Tnew rules; a monitor checks every cycle.
module tb_pipe_stage_elastic;

    localparam int DATA_W   = 128;
    localparam int TNEW_W   = 3;
    localparam int TNEW_MAX = 7;
    localparam int FWD_LSB  = 32;

    typedef struct {
        logic [31:0]       instr;
        logic [31:0]       pc;
        logic [DATA_W-1:0] data;
        logic [4:0]        wreg;
        int                tnew;
    } item_t;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [31:0]       in_instr = '0;
    logic [31:0]       in_pc = '0;
    logic [DATA_W-1:0] in_data = '0;
    logic [4:0]        in_wreg = '0;
    logic [TNEW_W-1:0] in_tnew = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [31:0]       out_instr;
    logic [31:0]       out_pc;
    logic [DATA_W-1:0] out_data;
    logic [4:0]        out_wreg;
    logic [TNEW_W-1:0] out_tnew;
    logic              fwd_en;
    logic [31:0]       fwd_val;

    item_t q[$];
    bit    pushed = 1'b0;
    int    n_cmp = 0;
    int    n_err = 0;
    int    n_txn = 0;
    int    occ;
    bit    rel;
    item_t head;

    always #5 clk = ~clk;

    pipe_stage_elastic #(
        .DATA_W   (DATA_W),
        .TNEW_W   (TNEW_W),
        .TNEW_MAX (TNEW_MAX),
        .FWD_LSB  (FWD_LSB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .in_pc     (in_pc),
        .in_data   (in_data),
        .in_wreg   (in_wreg),
        .in_tnew   (in_tnew),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_pc    (out_pc),
        .out_data  (out_data),
        .out_wreg  (out_wreg),
        .out_tnew  (out_tnew),
        .fwd_en    (fwd_en),
        .fwd_val   (fwd_val)
    );

    function automatic int sat_dec(input int t);
        return (t > 0) ? t - 1 : 0;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One cycle of stimulus; accepted items go straight into the scoreboard.
    task automatic cyc(input bit iv, input logic [31:0] ins, input logic [31:0] pc,
                       input logic [DATA_W-1:0] dat, input logic [4:0] wr, input int tn,
                       input bit ordy, input bit fl, input bit rs);
        item_t it;
        @(posedge clk);
        #1;
        in_valid  = iv;
        in_instr  = ins;
        in_pc     = pc;
        in_data   = dat;
        in_wreg   = wr;
        in_tnew   = TNEW_W'(tn);
        out_ready = ordy;
        flush     = fl;
        reset     = rs;
        pushed    = 1'b0;
        if (!rs && !fl && iv && in_ready) begin
            it.instr = ins;
            it.pc    = pc;
            it.data  = dat;
            it.wreg  = wr;
            it.tnew  = sat_dec(tn);
            q.push_back(it);
            pushed = 1'b1;
        end
    endtask

    task automatic idle(input bit ordy, input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 32'h0, 32'h0, '0, 5'd0, 0, ordy, 1'b0, 1'b0);
    endtask

    // Monitor: compares the DUT's current cycle against the model, then retires.
    always @(negedge clk) begin
        occ = q.size() - (pushed ? 1 : 0);
        if (reset) begin
            q.delete();
        end else begin
            chk("out_valid", 128'(out_valid), 128'(occ > 0));
            chk("in_ready", 128'(in_ready), 128'(occ < 2));
            if (occ > 0) begin
                head = q[0];
                chk("out_instr", 128'(out_instr), 128'(head.instr));
                chk("out_pc", 128'(out_pc), 128'(head.pc));
                chk("out_data", out_data, head.data);
                chk("out_wreg", 128'(out_wreg), 128'(head.wreg));
                chk("out_tnew", 128'(out_tnew), 128'(head.tnew));
                chk("fwd_en", 128'(fwd_en),
                    128'((head.wreg != 5'd0) && (head.tnew == 0)));
                chk("fwd_val", 128'(fwd_val), 128'(head.data[FWD_LSB +: 32]));
            end else begin
                chk("bubble_instr", 128'(out_instr), 128'(0));
                chk("bubble_tnew", 128'(out_tnew), 128'(TNEW_MAX));
                chk("bubble_fwd_en", 128'(fwd_en), 128'(0));
            end
            rel = (occ > 0) && out_ready;
            if (flush) begin
                q.delete();
            end else begin
                if (rel) begin
                    n_txn++;
                    $display("txn %0d: instr=%h pc=%h wreg=%0d tnew=%0d",
                             n_txn, q[0].instr, q[0].pc, q[0].wreg, q[0].tnew);
                    q.pop_front();
                end
`ifdef PIPE_TNEW_AGE_EN
                if (!rel) begin
                    for (int i = 0; i < occ; i++) q[i].tnew = sat_dec(q[i].tnew);
                end
`endif
            end
        end
    end

    localparam logic [DATA_W-1:0] PAYLOAD = 128'h0000_0000_1234_5678_CAFE_F00D_0000_0000;

    initial begin
        logic [DATA_W-1:0] rdat;
        cyc(1'b0, 32'h0, 32'h0, '0, 5'd0, 0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 32'h0, 32'h0, '0, 5'd0, 0, 1'b0, 1'b0, 1'b1);
        idle(1'b1, 2);

        // Streaming with Tnew countdown, saturation and wreg 0.
        cyc(1'b1, 32'h00221820, 32'h00400000, PAYLOAD, 5'd3, 2, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 32'h00221820, 32'h00400004, PAYLOAD, 5'd3, 1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 32'h00431020, 32'h00400008, PAYLOAD, 5'd2, 0, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 32'h00000020, 32'h0040000C, PAYLOAD, 5'd0, 1, 1'b1, 1'b0, 1'b0);
        idle(1'b1, 2);

        // Skid: stall with A in MAIN, B lands in SKID, C refused.
        cyc(1'b1, 32'hAAAA0001, 32'h00400100, PAYLOAD, 5'd4, 3, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'hBBBB0002, 32'h00400104, PAYLOAD, 5'd5, 1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'hCCCC0003, 32'h00400108, PAYLOAD, 5'd6, 2, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'hCCCC0003, 32'h00400108, PAYLOAD, 5'd6, 2, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'hCCCC0003, 32'h00400108, PAYLOAD, 5'd6, 2, 1'b0, 1'b0, 1'b0);
        idle(1'b1, 4);

        // Flush with both entries full and a valid input in the flush cycle.
        cyc(1'b1, 32'hDDDD0004, 32'h00400200, PAYLOAD, 5'd7, 2, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'hEEEE0005, 32'h00400204, PAYLOAD, 5'd8, 2, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'hFFFF0006, 32'h00400208, PAYLOAD, 5'd9, 2, 1'b0, 1'b1, 1'b0);
        idle(1'b1, 2);

        // Reset in mid-stall.
        cyc(1'b1, 32'h11110007, 32'h00400300, PAYLOAD, 5'd1, 4, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h22220008, 32'h00400304, PAYLOAD, 5'd2, 4, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h33330009, 32'h00400308, PAYLOAD, 5'd3, 4, 1'b0, 1'b0, 1'b1);
        idle(1'b1, 2);

        for (int n = 0; n < 3000; n++) begin
            rdat = {$urandom, $urandom, $urandom, $urandom};
            cyc($urandom_range(0, 3) != 0, $urandom, $urandom, rdat,
                ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                int'($urandom_range(0, 7)), $urandom_range(0, 2) != 0,
                $urandom_range(0, 49) == 0, $urandom_range(0, 299) == 0);
        end

        idle(1'b1, 5);
        @(negedge clk);
        #1;
        chk("drain_empty", 128'(q.size()), 128'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_stage_elastic.md
# pipe_stage_elastic

Parametrised elastic pipeline stage register for the five-stage MIPS core. It generalises the fixed inter-stage registers (IF/ID … MEM/WB) into one block with a configurable payload width, valid/ready handshake, a two-entry skid buffer, synchronous flush, saturating Tnew countdown and a built-in forwarding tap. Every inter-stage boundary is instantiated from this block, so stalls propagate by back-pressure instead of global enable wires.

## Interface
- DATA_W, 128, payload bits carried alongside instr/pc (e.g. PC8, ALUOut, RD)
- TNEW_W, 3, width of the Tnew field
- TNEW_MAX, 7, Tnew value of a bubble
- FWD_LSB, 32, bit offset in payload of the 32-bit forwarding value
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- flush  in  1  synchronous kill of both entries
- in_valid  in  1  upstream has an instruction
- in_ready  out  1  stage can accept
- in_instr  in  32  instruction word
- in_pc  in  32  instruction PC
- in_data  in  DATA_W  payload
- in_wreg  in  5  destination register (0 = none)
- in_tnew  in  TNEW_W  Tnew at the upstream stage
- out_valid  out  1  output entry holds an instruction
- out_ready  in  1  downstream accepts
- out_instr, out_pc  out  32  registered instr/pc
- out_data  out  DATA_W  registered payload
- out_wreg  out  5  registered destination
- out_tnew  out  TNEW_W  registered Tnew
- fwd_en  out  1  out_valid && out_wreg!=0 && out_tnew==0
- fwd_val  out  32  out_data[FWD_LSB +: 32]

## Operation
- Two entries: MAIN (drives out_*) and SKID. in_ready = !SKID.valid, a registered signal, never combinational from out_ready.
- Accept = in_valid && in_ready; Release = out_valid && out_ready.
- Capture writes tnew = (in_tnew > 0) ? in_tnew-1 : 0 (saturating).
- Per cycle, by (MAIN.valid, SKID.valid, Accept, Release):
  - MAIN empty, Accept -> MAIN <= input.
  - MAIN full, Release, SKID empty -> MAIN <= input if Accept, else bubble.
  - MAIN full, Release, SKID full -> MAIN <= SKID, SKID <= bubble (Accept impossible).
  - MAIN full, no Release, Accept -> SKID <= input.
  - otherwise hold.
- Bubble = valid 0, instr 0, pc 0, data 0, wreg 0, tnew TNEW_MAX.
- Held entries keep their tnew unless PIPE_TNEW_AGE_EN.
- flush: next cycle both entries are bubble; an Accept in the flush cycle is discarded. reset has priority over flush.
- Order preserved: SKID is always younger than MAIN; SKID never valid while MAIN empty.

## Timing
- Reset values: out_valid 0, out_instr/out_pc/out_data/out_wreg 0, out_tnew TNEW_MAX, in_ready 1, fwd_en 0.
- Latency 1 cycle input->output; throughput 1 per cycle with out_ready held high.
- Stall entry: first cycle out_ready low still accepts into SKID; in_ready falls the following cycle.
- Stall exit: MAIN<-SKID on the first out_ready cycle; in_ready rises the cycle after.
- Reset/flush in mid-stall drop both entries; no partial state survives.

## Configuration
- PIPE_TNEW_AGE_EN defined: every held valid entry (MAIN and SKID) decrements tnew each cycle, saturating at 0, for multicycle units whose result matures while stalled.
- Undefined: tnew changes only at capture; MAIN<-SKID move carries tnew unchanged.

## Structure
- Shared package/header: TNEW_MAX default, bubble constants (NOP word 32'h0), register-zero index, saturating-decrement function.
- One sub-module: pipe_entry (one valid+fields register with load/clear/age controls), instantiated twice for MAIN and SKID; top-level holds the control logic.

## Test plan
- Reset: assert reset 1 cycle -> out_valid 0, out_tnew 7, out_instr 0, in_ready 1.
- Streaming: out_ready=1, feed instr 0x00221820 with tnew 2, wreg 3 -> next cycle out_tnew 1, out_wreg 3, fwd_en 0; tnew 1 input -> out_tnew 0, fwd_en 1, fwd_val = payload[63:32].
- Skid: out_ready=0 with A in MAIN, accept B -> in_ready 0 next cycle; raise out_ready -> A released, then B on out_* next cycle, in_ready 1, no loss or duplication.
- Saturation: in_tnew 0 -> out_tnew 0; wreg 0 with tnew 1 -> fwd_en always 0.
- Flush: both entries full, flush with in_valid=1 -> next cycle out_valid 0, out_instr 0, out_tnew 7, in_ready 1, input dropped.
- Aging (macro on): stall 3 cycles with captured tnew 2 -> out_tnew 2,1,0,0; macro off -> 2 throughout.
